// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite memory target: word-organised SRAM with byte lanes, fixed wait
// states per OKAY data phase and a two-cycle ERROR response for bad transfers.
//
// state | meaning
// IDLE  | no data phase in progress, ready for an address phase
// WAIT  | OKAY transfer stalled, wcnt cycles remaining
// DATA  | final data-phase cycle, read data driven / write committed
// ERR1  | first ERROR cycle (hreadyout low)
// ERR2  | second ERROR cycle (hreadyout high), pipelined accept allowed
module ahb_lite_sram_slave #(
   parameter int HADDR_SIZE  = 32,
   parameter int HDATA_SIZE  = 32,
   parameter int MEM_DEPTH   = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic                  hclk,
   input  logic                  hresetn,
   input  logic                  hsel,
   input  logic [HADDR_SIZE-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [2:0]            hburst,
   input  logic [3:0]            hprot,
   input  logic [HDATA_SIZE-1:0] hwdata,
   input  logic                  hready,
   output logic                  hreadyout,
   output logic                  hresp,
   output logic [HDATA_SIZE-1:0] hrdata
);

   localparam int LANES     = HDATA_SIZE / 8;
   localparam int LANE_BITS = $clog2(LANES);
   localparam int IDX_BITS  = $clog2(MEM_DEPTH);
   localparam int TOP_BIT   = LANE_BITS + IDX_BITS;
   localparam logic [2:0] WS = 3'(WAIT_STATES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t               state, state_nxt;
   logic [2:0]           wcnt, wcnt_nxt;
   logic [IDX_BITS-1:0]  a_idx;
   logic [LANE_BITS-1:0] a_off;
   logic [2:0]           a_size;
   logic                 a_write;
   logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

   logic                 can_accept;
   logic                 accept;
   logic [7:0]           align_mask;
   logic                 bad_size;
   logic                 misaligned;
   logic                 out_of_range;
   logic                 addr_err;
   logic                 commit;
   logic [LANES-1:0]     be;

   // hburst/hprot carry no behaviour in this target
   logic unused_inputs;
   assign unused_inputs = ^{hburst, hprot};

   // address-phase qualification and transfer error classification
   always_comb begin
      can_accept   = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
      accept       = can_accept & hsel & hready & htrans[1];
      align_mask   = (8'd1 << hsize) - 8'd1;
      bad_size     = hsize > 3'(LANE_BITS);
      misaligned   = |(haddr[7:0] & align_mask);
      out_of_range = |haddr[HADDR_SIZE-1:TOP_BIT];
      addr_err     = bad_size | misaligned | out_of_range;
   end

   // next-state and wait-counter logic
   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      case (state)
         ST_WAIT: begin
            wcnt_nxt = wcnt - 3'd1;
            if (wcnt <= 3'd1) state_nxt = ST_DATA;
         end
         ST_ERR1: state_nxt = ST_ERR2;
         default: begin
            if (accept) begin
               if (addr_err) begin
                  state_nxt = ST_ERR1;
               end else if (WS != 3'd0) begin
                  state_nxt = ST_WAIT;
                  wcnt_nxt  = WS;
               end else begin
                  state_nxt = ST_DATA;
               end
            end else if (hready) begin
               state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   // state and wait-counter registers
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state <= ST_IDLE;
         wcnt  <= 3'd0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
      end
   end

   // capture the accepted address phase for the following data phase
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         a_idx   <= '0;
         a_off   <= '0;
         a_size  <= 3'd0;
         a_write <= 1'b0;
      end else if (accept) begin
         a_idx   <= haddr[TOP_BIT-1:LANE_BITS];
         a_off   <= haddr[LANE_BITS-1:0];
         a_size  <= hsize;
         a_write <= hwrite;
      end
   end

   // little-endian byte enables from registered size and lane offset
   always_comb begin
      be = '0;
      for (int i = 0; i < LANES; i++) begin
         if ((i >= int'(a_off)) && (i < int'(a_off) + (1 << a_size))) be[i] = 1'b1;
      end
   end

   assign commit = (state == ST_DATA) & a_write & hready;

   // memory write on the edge ending the DATA cycle; contents survive reset
   always_ff @(posedge hclk) begin
      if (hresetn && commit) begin
         for (int i = 0; i < LANES; i++) begin
            if (be[i]) mem[a_idx][8*i +: 8] <= hwdata[8*i +: 8];
         end
      end
   end

   assign hreadyout = !((state == ST_WAIT) || (state == ST_ERR1));
   assign hresp     = (state == ST_ERR1) || (state == ST_ERR2);
   assign hrdata    = ((state == ST_DATA) && !a_write) ? mem[a_idx] : '0;

endmodule

// File: doc/ahb_lite_sram_slave.md
# ahb_lite_sram_slave

Parametrised AHB-Lite slave with an internal word-organised memory, programmable wait states, byte/halfword/word lanes and a two-cycle ERROR response. It is the bus-facing memory target that the `dut_if` master/monitor environment drives. It generalises the fixed 32-bit/4-entry slave by making data width, depth and latency configurable, and adds error signalling for bad transfers.

## Interface
- HADDR_SIZE, 32, address bus width
- HDATA_SIZE, 32, data bus width; legal values are 32 and 64
- MEM_DEPTH, 16, number of HDATA_SIZE-bit words; must be a power of two, 2 or more
- WAIT_STATES, 0, wait cycles inserted per OKAY data phase; range 0–7
---
- hclk  in  1  clock; all logic is on the rising edge
- hresetn  in  1  reset; synchronous, active-low
- hsel  in  1  slave select
- haddr  in  HADDR_SIZE  byte address
- htrans  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hwrite  in  1  1 = write
- hsize  in  3  transfer size, 2^hsize bytes
- hburst  in  3  burst type; informational only, no behaviour depends on it
- hprot  in  4  protection; ignored
- hwdata  in  HDATA_SIZE  write data, valid in the data phase
- hready  in  1  bus-level ready; an address phase is qualified only when it is 1
- hreadyout  out  1  slave ready
- hresp  out  1  0 = OKAY, 1 = ERROR
- hrdata  out  HDATA_SIZE  read data

## Operation
- **Address-phase accept.** A transfer is accepted on an edge where hsel & hready & htrans[1] = 1.
  - At that edge the slave registers haddr, hwrite and hsize, plus an error flag.
  - IDLE or BUSY transfers, or hsel = 0, produce no access and a zero-wait OKAY.
- **Error conditions.** The error flag is set when any of the following holds:
  - hsize exceeds log2(HDATA_SIZE/8);
  - the address is misaligned: haddr[hsize-1:0] ≠ 0;
  - the address is out of range: haddr ≥ MEM_DEPTH·HDATA_SIZE/8.
- **Byte lanes.** Lanes are little-endian. The lane offset is haddr[log2(HDATA_SIZE/8)-1:0]. A write updates only the lanes selected by size and offset; all other bytes are unchanged.
- **State machine** (state is IDLE at reset):
  - IDLE: hreadyout = 1, hresp = 0.
    - Accept of an errored transfer → ERR1.
    - Accept with WAIT_STATES > 0 → WAIT, loading wcnt = WAIT_STATES.
    - Accept with WAIT_STATES = 0 → DATA.
  - WAIT: hreadyout = 0, hresp = 0. wcnt decrements each cycle; when wcnt reaches 1, go to DATA.
  - DATA: hreadyout = 1, hresp = 0. The access completes at this edge: a write commits hwdata to memory.
    - A new accept in the same cycle (pipelined) is evaluated exactly as in IDLE.
    - Otherwise → IDLE.
  - ERR1: hreadyout = 0, hresp = 1 → ERR2.
  - ERR2: hreadyout = 1, hresp = 1. Memory is never written. A new accept is evaluated as in IDLE; otherwise → IDLE.
- **Read data.** hrdata = mem[registered word index] in DATA when the registered transfer is a read, and 0 at all other times (including WAIT and ERR states).
- **Read-after-write.** A read whose data phase directly follows a write's DATA cycle to the same word returns the newly written bytes.
- **Reset.** When hresetn = 0 at an edge:
  - state → IDLE, hreadyout = 1, hresp = 0, hrdata = 0, wcnt = 0;
  - any in-flight write is dropped;
  - memory contents are retained across reset and are undefined at power-up.

## Timing
- Read latency with WAIT_STATES = 0: data is valid in the cycle after the address phase.
- General data-phase length is WAIT_STATES + 1 cycles.
- ERROR transfers always take 2 data-phase cycles, regardless of WAIT_STATES.
- Write data is sampled on the edge that ends the hreadyout = 1 data-phase cycle.
- Back-to-back accesses: with WAIT_STATES = 0, sustained throughput is one transfer per cycle.
- hready = 0 (another slave is stalling): no address phase is sampled and current outputs are held.
- A transfer that errors in ERR1 does not block pipelining: the master may present IDLE or a new transfer during ERR2.
- All outputs are registered from state; hreadyout/hresp have no combinational path from inputs.

## Test plan
- **Reset:** hresetn = 0 for 2 cycles, then 1 → hreadyout = 1, hresp = 0, hrdata = 0.
- **Word write/read, WAIT_STATES = 0:** write 0xDEADBEEF to 0x8, then read 0x8 back-to-back → hrdata = 0xDEADBEEF in the cycle after the read address phase; each transfer is 1 cycle.
- **Byte lanes:** write word 0x11223344 to 0x4, then byte write 0xAA at 0x6 (hsize = 0, hwdata = 0x00AA0000) → reading 0x4 returns 0x11AA3344.
- **Wait states, WAIT_STATES = 2:** a read at 0x0 shows hreadyout = 0 for 2 cycles, then hreadyout = 1 with valid data.
- **Errors:** each of the following gives hreadyout/hresp = 0/1 then 1/1, and memory stays unchanged:
  - halfword at 0x1 (misaligned);
  - address 0x40 with MEM_DEPTH = 16 (out of range);
  - hsize = 3 on a 32-bit bus.
- **Reset mid-operation:** hresetn = 0 in the WAIT cycle of a write → state returns to IDLE with hreadyout = 1, and the target word keeps its old value.
